// File: rtl/instruction_fetch_ctrl_pkg.sv
// Shared constants and types for the instruction fetch controller and its buffer.
package instruction_fetch_ctrl_pkg;

  localparam int WORD_W      = 32;
  localparam int FETCH_DEPTH = 2;
  localparam int PTR_W       = $clog2(FETCH_DEPTH);
  localparam int CNT_W       = $clog2(FETCH_DEPTH + 1);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQ     = 2'd1,
    ST_WAIT    = 2'd2,
    ST_DISCARD = 2'd3
  } fetch_state_e;

  typedef struct packed {
    logic [WORD_W-1:0] pc;
    logic [WORD_W-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/instruction_fetch_ctrl_buffer.sv
// Small FIFO of fetched {pc, instruction} pairs; flush empties it and wins over push/pop.
module fetch_buffer
  import instruction_fetch_ctrl_pkg::*;
(
  input  logic               Clk,
  input  logic               Reset,
  input  logic               push_i,
  input  logic               pop_i,
  input  logic               flush_i,
  input  fetch_entry_t       push_entry_i,
  output fetch_entry_t       head_o,
  output logic [CNT_W-1:0]   count_o,
  output logic               valid_o
);

  fetch_entry_t           mem_q [FETCH_DEPTH];
  logic [PTR_W-1:0]       rd_ptr_q;
  logic [PTR_W-1:0]       wr_ptr_q;
  logic [CNT_W-1:0]       count_q;
  logic                   do_pop;
  logic                   do_push;

  assign valid_o = (count_q != '0);
  assign do_pop  = pop_i && valid_o;
  // A push into a full buffer is only legal when the head leaves the same cycle.
  assign do_push = push_i && ((count_q < CNT_W'(FETCH_DEPTH)) || do_pop);

  // Depth is a power of two, so the pointers wrap naturally.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < FETCH_DEPTH; i++) mem_q[i] <= '0;
    end else if (flush_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= push_entry_i;
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (do_pop) rd_ptr_q <= rd_ptr_q + 1'b1;
      if (do_push && !do_pop)      count_q <= count_q + 1'b1;
      else if (do_pop && !do_push) count_q <= count_q - 1'b1;
    end
  end

  assign head_o  = valid_o ? mem_q[rd_ptr_q] : '0;
  assign count_o = count_q;

endmodule

// File: rtl/instruction_fetch_ctrl.sv
// Instruction fetch controller: one outstanding memory read at a time, results queued for decode.
module instruction_fetch_ctrl
  import instruction_fetch_ctrl_pkg::*;
(
  input  logic              Clk,
  input  logic              Reset,
  input  logic [WORD_W-1:0] PCAddress,
  output logic              PCWrite,
  output logic              MemReq,
  output logic [WORD_W-1:0] MemAddr,
  input  logic              MemGnt,
  input  logic              MemRValid,
  input  logic [WORD_W-1:0] MemRData,
  output logic [WORD_W-1:0] Instruction,
  output logic [WORD_W-1:0] InstrPC,
  output logic              InstrValid,
  input  logic              DecodeStall,
  input  logic              Flush
);

  fetch_state_e       state_q;
  logic [WORD_W-1:0]  req_addr_q;
  logic [CNT_W-1:0]   count;
  logic               grant;
  logic               push;
  logic               pop;
  fetch_entry_t       push_entry;
  fetch_entry_t       head;

  // Request is combinational so the grant can be taken in the same cycle.
  assign MemReq  = (state_q == ST_REQ) && (count < CNT_W'(FETCH_DEPTH)) && !Flush;
  assign MemAddr = MemReq ? PCAddress : '0;
  assign grant   = MemReq && MemGnt;
  assign PCWrite = !Reset || !(Flush || grant);

  assign push       = (state_q == ST_WAIT) && MemRValid && !Flush;
  assign pop        = InstrValid && !DecodeStall;
  assign push_entry = '{pc: req_addr_q, instr: MemRData};

  fetch_buffer u_buffer (
    .Clk          (Clk),
    .Reset        (Reset),
    .push_i       (push),
    .pop_i        (pop),
    .flush_i      (Flush),
    .push_entry_i (push_entry),
    .head_o       (head),
    .count_o      (count),
    .valid_o      (InstrValid)
  );

  assign Instruction = head.instr;
  assign InstrPC     = head.pc;

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q    <= ST_IDLE;
      req_addr_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE: state_q <= ST_REQ;
        ST_REQ: begin
          if (grant) begin
            req_addr_q <= PCAddress;
            state_q    <= ST_WAIT;
          end
        end
        // A flushed request still owes a response; DISCARD swallows it.
        ST_WAIT: begin
          if (Flush)          state_q <= MemRValid ? ST_REQ : ST_DISCARD;
          else if (MemRValid) state_q <= ST_REQ;
        end
        ST_DISCARD: begin
          if (MemRValid) state_q <= ST_REQ;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_instruction_fetch_ctrl.sv
// Directed bench for instruction_fetch_ctrl with a scoreboard of expected decode-side words.
module tb_instruction_fetch_ctrl;

  logic        Clk = 1'b0;
  logic        Reset = 1'b0;
  logic [31:0] PCAddress = '0;
  logic        MemGnt = 1'b0;
  logic        MemRValid = 1'b0;
  logic [31:0] MemRData = '0;
  logic        DecodeStall = 1'b0;
  logic        Flush = 1'b0;
  logic        PCWrite;
  logic        MemReq;
  logic [31:0] MemAddr;
  logic [31:0] Instruction;
  logic [31:0] InstrPC;
  logic        InstrValid;

  int checks = 0;
  int errors = 0;
  int pcw_lo = 0;
  logic [63:0] sb [$];

  instruction_fetch_ctrl dut (
    .Clk         (Clk),
    .Reset       (Reset),
    .PCAddress   (PCAddress),
    .PCWrite     (PCWrite),
    .MemReq      (MemReq),
    .MemAddr     (MemAddr),
    .MemGnt      (MemGnt),
    .MemRValid   (MemRValid),
    .MemRData    (MemRData),
    .Instruction (Instruction),
    .InstrPC     (InstrPC),
    .InstrValid  (InstrValid),
    .DecodeStall (DecodeStall),
    .Flush       (Flush)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: every word decode consumes must be the next expected one.
  always @(negedge Clk) begin
    logic [63:0] e;
    if (Reset) begin
      if (!PCWrite) pcw_lo++;
      if (InstrValid && !DecodeStall && !Flush) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_instr: got pc 0x%08h word 0x%08h expected none", InstrPC, Instruction);
        end else begin
          e = sb.pop_front();
          chk("instr_pc", InstrPC, e[63:32]);
          chk("instr_word", Instruction, e[31:0]);
        end
      end
    end
  end

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic grant_only(input logic [31:0] addr);
    bit got = 1'b0;
    PCAddress = addr;
    MemGnt    = 1'b1;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge Clk);
      if (MemReq) begin
        got = 1'b1;
        chk("grant_memaddr", MemAddr, addr);
        chk("grant_pcwrite", PCWrite, 32'd0);
      end
      tick();
    end
    MemGnt = 1'b0;
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL grant_timeout: got no MemReq for 0x%08h expected MemReq=1", addr);
    end
  endtask

  task automatic respond(input logic [31:0] data);
    MemRValid = 1'b1;
    MemRData  = data;
    tick();
    MemRValid = 1'b0;
  endtask

  task automatic fetch(input logic [31:0] addr, input logic [31:0] data);
    grant_only(addr);
    respond(data);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_memreq"},  MemReq, 32'd0);
    chk({tag, "_memaddr"}, MemAddr, 32'd0);
    chk({tag, "_pcwrite"}, PCWrite, 32'd1);
    chk({tag, "_ivalid"},  InstrValid, 32'd0);
    chk({tag, "_instr"},   Instruction, 32'd0);
    chk({tag, "_instrpc"}, InstrPC, 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int p0;
    // Reset hold, then the single minimum-latency fetch.
    repeat (3) tick();
    @(negedge Clk);
    check_reset_outputs("rst_hold");
    tick();
    Reset = 1'b1;
    @(negedge Clk);
    chk("idle_memreq", MemReq, 32'd0);
    chk("idle_pcwrite", PCWrite, 32'd1);
    tick();
    p0 = pcw_lo;
    sb.push_back({32'h0000_0000, 32'h2008_0005});
    grant_only(32'h0000_0000);
    MemRValid = 1'b1;
    MemRData  = 32'h2008_0005;
    @(negedge Clk);
    chk("lat_n1_ivalid", InstrValid, 32'd0);
    chk("lat_n1_pcwrite", PCWrite, 32'd1);
    tick();
    MemRValid = 1'b0;
    @(negedge Clk);
    chk("lat_n2_ivalid", InstrValid, 32'd1);
    tick();
    tick();
    chk("pcwrite_pulses", 32'(pcw_lo - p0), 32'd1);

    // Buffer fills under stall, then drains in order.
    DecodeStall = 1'b1;
    sb.push_back({32'h0000_0000, 32'hA000_0000});
    sb.push_back({32'h0000_0004, 32'hA000_0004});
    sb.push_back({32'h0000_0008, 32'hA000_0008});
    sb.push_back({32'h0000_000C, 32'hA000_000C});
    fetch(32'h0000_0000, 32'hA000_0000);
    fetch(32'h0000_0004, 32'hA000_0004);
    PCAddress = 32'h0000_0008;
    MemGnt    = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge Clk);
      chk("full_memreq", MemReq, 32'd0);
      chk("full_pcwrite", PCWrite, 32'd1);
      chk("full_head_pc", InstrPC, 32'h0000_0000);
      tick();
    end
    MemGnt      = 1'b0;
    DecodeStall = 1'b0;
    fetch(32'h0000_0008, 32'hA000_0008);
    fetch(32'h0000_000C, 32'hA000_000C);
    repeat (4) tick();
    chk("drain_sb_empty", 32'(sb.size()), 32'd0);

    // Flush while waiting: late response is discarded, redirect address used.
    DecodeStall = 1'b1;
    grant_only(32'h0000_0010);
    Flush     = 1'b1;
    PCAddress = 32'h0000_0040;
    @(negedge Clk);
    chk("flush_wait_pcwrite", PCWrite, 32'd0);
    chk("flush_wait_memreq", MemReq, 32'd0);
    tick();
    Flush = 1'b0;
    @(negedge Clk);
    chk("discard_memreq", MemReq, 32'd0);
    tick();
    respond(32'hDEAD_BEEF);
    DecodeStall = 1'b0;
    @(negedge Clk);
    chk("discard_ivalid", InstrValid, 32'd0);
    tick();
    sb.push_back({32'h0000_0040, 32'h1111_2222});
    fetch(32'h0000_0040, 32'h1111_2222);
    repeat (3) tick();
    chk("redirect_sb_empty", 32'(sb.size()), 32'd0);

    // Flush coincident with response while one entry is buffered.
    DecodeStall = 1'b1;
    fetch(32'h0000_0080, 32'h0BAD_F00D);
    @(negedge Clk);
    chk("one_entry_ivalid", InstrValid, 32'd1);
    tick();
    grant_only(32'h0000_0084);
    Flush     = 1'b1;
    MemRValid = 1'b1;
    MemRData  = 32'hCAFE_0001;
    PCAddress = 32'h0000_0200;
    @(negedge Clk);
    chk("flush_rv_pcwrite", PCWrite, 32'd0);
    tick();
    Flush     = 1'b0;
    MemRValid = 1'b0;
    @(negedge Clk);
    chk("flush_rv_ivalid", InstrValid, 32'd0);
    chk("flush_rv_memreq", MemReq, 32'd1);
    chk("flush_rv_memaddr", MemAddr, 32'h0000_0200);
    tick();
    @(negedge Clk);
    chk("flush_rv_ivalid2", InstrValid, 32'd0);
    tick();

    // Reset in the middle of WAIT with a stray response after release.
    DecodeStall = 1'b0;
    grant_only(32'h0000_0300);
    Reset = 1'b0;
    @(negedge Clk);
    check_reset_outputs("rst_wait");
    tick();
    Reset     = 1'b1;
    MemRValid = 1'b1;
    MemRData  = 32'hBAD0_BAD0;
    @(negedge Clk);
    check_reset_outputs("rst_release");
    tick();
    tick();
    MemRValid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge Clk);
      chk("stray_ivalid", InstrValid, 32'd0);
      tick();
    end
    chk("final_sb_empty", 32'(sb.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/instruction_fetch_ctrl.md
INSTRUCTION_FETCH_CTRL -- requirements
Module: instruction_fetch_ctrl

Interface
REQ-001 Clk  in  1  sole clock; all state updates on posedge Clk.
REQ-002 Reset  in  1  asynchronous, active-low reset (Reset=0 resets).
REQ-003 PCAddress  in  32  current PC register output; fetch address source.
REQ-004 PCWrite  out  1  PC hold control to the PC register: 1 = PC holds, 0 = PC loads its next Address.
REQ-005 MemReq  out  1  instruction-memory read request.
REQ-006 MemAddr  out  32  read address; valid while MemReq=1.
REQ-007 MemGnt  in  1  memory accepts the request this cycle; meaningful only while MemReq=1.
REQ-008 MemRValid  in  1  one-cycle read-data strobe; at most one per granted request, earliest one cycle after grant.
REQ-009 MemRData  in  32  read data; valid with MemRValid.
REQ-010 Instruction  out  32  head-of-buffer instruction word to decode.
REQ-011 InstrPC  out  32  fetch address of Instruction.
REQ-012 InstrValid  out  1  Instruction/InstrPC valid.
REQ-013 DecodeStall  in  1  decode cannot accept; head is not consumed while 1.
REQ-014 Flush  in  1  one-cycle redirect (taken branch/jump); PC loads the target this cycle.

Function
REQ-015 The FSM SHALL have states IDLE, REQ, WAIT, DISCARD; IDLE->REQ on the first cycle after Reset deasserts.
REQ-016 In REQ, MemReq=1 and MemAddr=PCAddress iff buffer count<2 and Flush=0; otherwise MemReq=0.
REQ-017 REQ with MemReq=1 and MemGnt=1: latch PCAddress into ReqAddr, drive PCWrite=0 for exactly that cycle, go to WAIT.
REQ-018 PCWrite SHALL be 1 in every other cycle, except PCWrite=0 in any cycle where Flush=1.
REQ-019 Exactly one request SHALL be outstanding at a time; MemReq=0 in WAIT and DISCARD.
REQ-020 WAIT with MemRValid=1: push {ReqAddr, MemRData} into the 2-entry buffer and go to REQ.
REQ-021 The buffer SHALL be FIFO; InstrValid=1 iff count>0; head pops when InstrValid=1 and DecodeStall=0.
REQ-022 Push and pop in the same cycle SHALL leave count unchanged and preserve order; overflow is impossible by REQ-016.
REQ-023 Minimum latency: grant at cycle N, MemRValid at N+1, InstrValid=1 with that word at N+2.
REQ-024 Flush=1 SHALL empty the buffer (InstrValid=0 next cycle) and suppress MemReq that cycle.
REQ-025 Flush in WAIT without MemRValid -> DISCARD; Flush in WAIT with MemRValid the same cycle -> REQ, and the response is dropped.
REQ-026 DISCARD SHALL drop the next MemRValid without pushing, then go to REQ; a Flush in DISCARD stays in DISCARD.
REQ-027 Flush in IDLE or REQ SHALL stay in or go to REQ; no grant is taken in that cycle.
REQ-028 Flush has priority over pop, push and grant in the same cycle.
REQ-029 Addresses SHALL pass through unmodified; no PC arithmetic in this block.

Reset
REQ-030 While Reset=0, the block SHALL hold: state=IDLE, count=0, MemReq=0, MemAddr=0, PCWrite=1, InstrValid=0, Instruction=0, InstrPC=0, ReqAddr=0.
REQ-031 Reset asserted mid-WAIT SHALL abandon the outstanding request; no response may be pushed after reset release.

Structure
REQ-032 The shared package SHALL hold the FSM state encoding, FETCH_DEPTH=2 and the 32-bit word width constant.
REQ-033 The buffer SHALL be a sub-module fetch_buffer (2-entry FIFO with push, pop, flush, count, head data).

Verification
REQ-034 Reset release, PCAddress=0x00000000, MemGnt=1, MemRValid the next cycle with 0x20080005 -> exactly one PCWrite=0 pulse; InstrValid=1 with Instruction=0x20080005, InstrPC=0x0 two cycles after grant.
REQ-035 DecodeStall=1 held, four grants at 0x0/0x4/0x8/0xC -> only 0x0 and 0x4 fetched, MemReq=0 and PCWrite=1 while count=2; after DecodeStall=0, order 0x0, 0x4, 0x8, 0xC.
REQ-036 Flush while in WAIT (addr 0x10), late MemRValid data 0xDEADBEEF -> word never appears; next fetch uses the redirected PCAddress 0x40.
REQ-037 Flush and MemRValid in the same cycle with the buffer holding 1 entry -> buffer empty next cycle; state REQ.
REQ-038 Reset=0 asserted while in WAIT, then released, with a stray MemRValid -> InstrValid stays 0 and all outputs equal REQ-030 values.
